// File: rtl/irq_hst_ctrl_mc_pkg.sv
// Shared TLP codes, register selectors, FSM state type and payload byte-swap
// for the host interrupt-control decoder.
package irq_hst_ctrl_mc_pkg;

  localparam logic [6:0] MEM_WR32_FMT_TYPE = 7'b10_00000;
  localparam logic [6:0] MEM_WR64_FMT_TYPE = 7'b11_00000;

  typedef enum logic [1:0] {
    REG_EN   = 2'd0,
    REG_DIS  = 2'd1,
    REG_THR  = 2'd2,
    REG_RSVD = 2'd3
  } reg_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_A32,
    ST_A64,
    ST_DATA
  } state_e;

  function automatic logic [31:0] dw_endian_conv(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/irq_hst_reg_dec.sv
// Combinational decode of one payload DW into per-channel EN/DIS/THR write
// one-hots plus the threshold value carried by the (already byte-swapped) DW.
module irq_hst_reg_dec
  import irq_hst_ctrl_mc_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter logic [5:0]  REG_BASE = 6'h10,
  parameter int unsigned THR_W    = 30
) (
  input  logic [5:0]        dw_addr_i,
  input  logic [31:0]       dw_i,
  input  logic              valid_i,
  output logic [NUM_CH-1:0] en_o,
  output logic [NUM_CH-1:0] dis_o,
  output logic [NUM_CH-1:0] thr_wr_o,
  output logic [THR_W-1:0]  thr_o
);

  logic [5:0] off;
  logic [3:0] ch;
  reg_sel_e   rsel;
  logic       unused_dw;

  assign unused_dw = ^dw_i;
  assign thr_o     = dw_i[THR_W+1:2];

  always_comb begin
    en_o     = '0;
    dis_o    = '0;
    thr_wr_o = '0;
    off      = dw_addr_i - REG_BASE;
    ch       = off[5:2];
    rsel     = reg_sel_e'(off[1:0]);
    // Addresses below REG_BASE would wrap into a valid-looking offset; reject them first.
    if (valid_i && (dw_addr_i >= REG_BASE)) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if ({28'd0, ch} == c) begin
          case (rsel)
            REG_EN:  en_o[c]     = 1'b1;
            REG_DIS: dis_o[c]    = 1'b1;
            REG_THR: thr_wr_o[c] = 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/irq_hst_ctrl_mc.sv
// Host interrupt-control register decoder: snoops TRN rx MWr32/MWr64 TLPs on one
// BAR and turns writes to per-channel EN/DIS/THR registers into IRQ controls.
module irq_hst_ctrl_mc
  import irq_hst_ctrl_mc_pkg::*;
#(
  parameter int unsigned       BARHIT   = 2,
  parameter int unsigned       NUM_CH   = 4,
  parameter logic [5:0]        REG_BASE = 6'h10,
  parameter int unsigned       THR_W    = 30,
  parameter logic [THR_W-1:0]  THR_RST  = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [63:0]               trn_rd,
  input  logic [7:0]                trn_rrem_n,
  input  logic                      trn_rsof_n,
  input  logic                      trn_reof_n,
  input  logic                      trn_rsrc_rdy_n,
  input  logic [6:0]                trn_rbar_hit_n,
  output logic [NUM_CH-1:0]         irq_en,
  output logic [NUM_CH-1:0]         irq_dis,
  output logic [NUM_CH*THR_W-1:0]   irq_thr,
  output logic [NUM_CH-1:0]         irq_thr_upd
);

  state_e                    state_q;
  logic [10:0]               len_q;
  logic [5:0]                dw_addr_q;
  logic [NUM_CH-1:0]         irq_en_q, irq_dis_q, irq_thr_upd_q;
  logic [NUM_CH*THR_W-1:0]   irq_thr_q;

  logic        beat, sof, eof, hit, unused_bar;
  logic [10:0] hdr_len;
  logic        hi_vld, lo_vld;
  logic [5:0]  hi_addr, lo_addr;
  logic [1:0]  dw_cnt;
  logic [31:0] hi_dw, lo_dw;

  logic [NUM_CH-1:0] en_hi, dis_hi, thr_wr_hi, en_lo, dis_lo, thr_wr_lo;
  logic [THR_W-1:0]  thr_hi, thr_lo;

  assign unused_bar = ^trn_rbar_hit_n;

  always_comb begin
    beat    = ~trn_rsrc_rdy_n;
    sof     = ~trn_rsof_n;
    eof     = ~trn_reof_n;
    hit     = ~trn_rbar_hit_n[BARHIT];
    hdr_len = {trn_rd[41:32] == 10'd0, trn_rd[41:32]};
    hi_dw   = dw_endian_conv(trn_rd[63:32]);
    lo_dw   = dw_endian_conv(trn_rd[31:0]);
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    hi_addr = dw_addr_q;
    lo_addr = dw_addr_q + 6'd1;
    if (beat && !sof) begin
      case (state_q)
        ST_A32: begin
          lo_vld  = 1'b1;
          lo_addr = trn_rd[39:34];
        end
        ST_DATA: begin
          hi_vld = 1'b1;
          lo_vld = (len_q > 11'd1) && !(eof && (trn_rrem_n == 8'h0F));
        end
        default: ;
      endcase
    end
    dw_cnt = lo_vld ? 2'd2 : 2'd1;
  end

  irq_hst_reg_dec #(.NUM_CH(NUM_CH), .REG_BASE(REG_BASE), .THR_W(THR_W)) u_dec_hi (
    .dw_addr_i (hi_addr),
    .dw_i      (hi_dw),
    .valid_i   (hi_vld),
    .en_o      (en_hi),
    .dis_o     (dis_hi),
    .thr_wr_o  (thr_wr_hi),
    .thr_o     (thr_hi)
  );

  irq_hst_reg_dec #(.NUM_CH(NUM_CH), .REG_BASE(REG_BASE), .THR_W(THR_W)) u_dec_lo (
    .dw_addr_i (lo_addr),
    .dw_i      (lo_dw),
    .valid_i   (lo_vld),
    .en_o      (en_lo),
    .dis_o     (dis_lo),
    .thr_wr_o  (thr_wr_lo),
    .thr_o     (thr_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      dw_addr_q     <= '0;
      irq_en_q      <= '0;
      irq_dis_q     <= '0;
      irq_thr_upd_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) irq_thr_q[c*THR_W +: THR_W] <= THR_RST;
    end else begin
      irq_en_q      <= en_hi | en_lo;
      irq_thr_upd_q <= thr_wr_hi | thr_wr_lo;
      // The lo DW is the higher-addressed one, so it takes priority within a beat.
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (dis_lo[c])      irq_dis_q[c] <= 1'b1;
        else if (en_lo[c])  irq_dis_q[c] <= 1'b0;
        else if (dis_hi[c]) irq_dis_q[c] <= 1'b1;
        else if (en_hi[c])  irq_dis_q[c] <= 1'b0;
        if (thr_wr_lo[c])      irq_thr_q[c*THR_W +: THR_W] <= thr_lo;
        else if (thr_wr_hi[c]) irq_thr_q[c*THR_W +: THR_W] <= thr_hi;
      end
      if (beat) begin
        if (sof) begin
          state_q <= ST_IDLE;
          len_q   <= hdr_len;
          if (hit && (trn_rd[3:0] != 4'h0)) begin
            if (trn_rd[62:56] == MEM_WR32_FMT_TYPE)      state_q <= ST_A32;
            else if (trn_rd[62:56] == MEM_WR64_FMT_TYPE) state_q <= ST_A64;
          end
        end else begin
          case (state_q)
            ST_A32: begin
              if ((len_q > 11'd1) && !eof) begin
                state_q   <= ST_DATA;
                len_q     <= len_q - 11'd1;
                dw_addr_q <= trn_rd[39:34] + 6'd1;
              end else begin
                state_q <= ST_IDLE;
              end
            end
            ST_A64: begin
              dw_addr_q <= trn_rd[7:2];
              state_q   <= eof ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
              len_q     <= len_q - {9'd0, dw_cnt};
              dw_addr_q <= dw_addr_q + {4'd0, dw_cnt};
              if (eof || (len_q <= {9'd0, dw_cnt})) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign irq_en      = irq_en_q;
  assign irq_dis     = irq_dis_q;
  assign irq_thr     = irq_thr_q;
  assign irq_thr_upd = irq_thr_upd_q;

endmodule

// File: tb/tb_irq_hst_ctrl_mc.sv
// Directed bench for irq_hst_ctrl_mc: per-beat expected outputs are queued when
// a beat is driven and popped one cycle later for comparison.
module tb_irq_hst_ctrl_mc;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned THR_W  = 30;

  logic                    clk;
  logic                    rst;
  logic [63:0]             trn_rd;
  logic [7:0]              trn_rrem_n;
  logic                    trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n;
  logic [6:0]              trn_rbar_hit_n;
  logic [NUM_CH-1:0]       irq_en, irq_dis, irq_thr_upd;
  logic [NUM_CH*THR_W-1:0] irq_thr;

  irq_hst_ctrl_mc #(
    .BARHIT(2), .NUM_CH(NUM_CH), .REG_BASE(6'h10), .THR_W(THR_W), .THR_RST('0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .trn_rd         (trn_rd),
    .trn_rrem_n     (trn_rrem_n),
    .trn_rsof_n     (trn_rsof_n),
    .trn_reof_n     (trn_reof_n),
    .trn_rsrc_rdy_n (trn_rsrc_rdy_n),
    .trn_rbar_hit_n (trn_rbar_hit_n),
    .irq_en         (irq_en),
    .irq_dis        (irq_dis),
    .irq_thr        (irq_thr),
    .irq_thr_upd    (irq_thr_upd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       dis;
    logic [NUM_CH-1:0]       upd;
    logic [NUM_CH*THR_W-1:0] thr;
  } exp_t;

  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;

  logic [NUM_CH-1:0] m_dis, pend_en, pend_upd;
  logic [THR_W-1:0]  m_thr [NUM_CH];

  localparam logic [6:0] FT_WR32 = 7'h40;
  localparam logic [6:0] FT_WR64 = 7'h60;
  localparam logic [6:0] FT_RD32 = 7'h00;

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [31:0] reg_addr(input int ch, input int r);
    return 32'((16 + 4 * ch + r) * 4);
  endfunction

  function automatic logic [63:0] hdr(input logic [6:0] ft, input logic [9:0] len, input logic [3:0] be);
    return {1'b0, ft, 14'd0, len, 16'h0001, 8'h00, (len == 10'd1) ? 4'h0 : 4'hF, be};
  endfunction

  task automatic model_reset();
    m_dis    = '0;
    pend_en  = '0;
    pend_upd = '0;
    for (int c = 0; c < NUM_CH; c++) m_thr[c] = '0;
  endtask

  // Record the architectural effect of one payload DW (raw bus order) on the model.
  task automatic expect_dw(input int ch, input int r, input logic [31:0] p);
    logic [31:0] s;
    s = swap32(p);
    case (r)
      0: begin pend_en[ch] = 1'b1; m_dis[ch] = 1'b0; end
      1: m_dis[ch] = 1'b1;
      2: begin m_thr[ch] = s[31:2]; pend_upd[ch] = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic push_exp();
    exp_t e;
    e.en  = pend_en;
    e.dis = m_dis;
    e.upd = pend_upd;
    for (int c = 0; c < NUM_CH; c++) e.thr[c*THR_W +: THR_W] = m_thr[c];
    sbq.push_back(e);
    pend_en  = '0;
    pend_upd = '0;
  endtask

  task automatic check(input string tag);
    exp_t e;
    e = sbq.pop_front();
    compared++;
    assert (irq_en === e.en) else begin
      mismatched++; $error("FAIL %s irq_en got %h exp %h", tag, irq_en, e.en);
    end
    compared++;
    assert (irq_dis === e.dis) else begin
      mismatched++; $error("FAIL %s irq_dis got %h exp %h", tag, irq_dis, e.dis);
    end
    compared++;
    assert (irq_thr_upd === e.upd) else begin
      mismatched++; $error("FAIL %s irq_thr_upd got %h exp %h", tag, irq_thr_upd, e.upd);
    end
    compared++;
    assert (irq_thr === e.thr) else begin
      mismatched++; $error("FAIL %s irq_thr got %h exp %h", tag, irq_thr, e.thr);
    end
  endtask

  task automatic beat(input string tag, input bit sof, input bit eof, input bit vld,
                      input logic [63:0] d, input logic [7:0] rem = 8'h00, input bit bar = 1'b1);
    trn_rsof_n     = ~sof;
    trn_reof_n     = ~eof;
    trn_rsrc_rdy_n = ~vld;
    trn_rd         = d;
    trn_rrem_n     = rem;
    trn_rbar_hit_n = bar ? 7'b1111011 : 7'b1111111;
    push_exp();
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) beat(tag, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_reset();
    beat(tag, 1'b0, 1'b0, 1'b0, 64'h0);
    rst = 1'b0;
  endtask

  task automatic check_thr(input string tag, input int ch, input logic [THR_W-1:0] v);
    compared++;
    assert (irq_thr[ch*THR_W +: THR_W] === v) else begin
      mismatched++; $error("FAIL %s thr[%0d] got %0d exp %0d", tag, ch, irq_thr[ch*THR_W +: THR_W], v);
    end
  endtask

  initial begin
    rst            = 1'b1;
    trn_rd         = '0;
    trn_rrem_n     = 8'h00;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rsrc_rdy_n = 1'b1;
    trn_rbar_hit_n = 7'h7F;
    model_reset();

    // 1) reset, no traffic
    do_reset("reset");
    idle("idle", 3);

    // 2) MWr32 len1 ch2 DIS, then ch2 EN
    beat("dis2_h", 1, 0, 1, hdr(FT_WR32, 10'd1, 4'hF));
    expect_dw(2, 1, 32'h1234_5678);
    beat("dis2_d", 0, 1, 1, {reg_addr(2, 1), 32'h1234_5678});
    idle("dis2_i", 1);
    beat("en2_h", 1, 0, 1, hdr(FT_WR32, 10'd1, 4'hF));
    expect_dw(2, 0, 32'h0);
    beat("en2_d", 0, 1, 1, {reg_addr(2, 0), 32'h0});
    idle("en2_i", 2);

    // 3) MWr64 len1 ch1 THR = LE 4096
    beat("thr1_h", 1, 0, 1, hdr(FT_WR64, 10'd1, 4'hF));
    beat("thr1_a", 0, 0, 1, {32'h0, reg_addr(1, 2)});
    expect_dw(1, 2, 32'h0010_0000);
    beat("thr1_d", 0, 1, 1, {32'h0010_0000, 32'h0}, 8'h0F);
    check_thr("thr1_val", 1, 30'd1024);
    idle("thr1_i", 1);

    // 4) MWr32 len4 burst at ch0 EN with stalls
    beat("bst_h", 1, 0, 1, hdr(FT_WR32, 10'd4, 4'hF));
    beat("bst_s0", 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_dw(0, 0, 32'hAAAA_AAAA);
    beat("bst_d0", 0, 0, 1, {reg_addr(0, 0), 32'hAAAA_AAAA});
    beat("bst_s1", 0, 0, 0, 64'h0);
    expect_dw(0, 1, 32'h0);
    expect_dw(0, 2, 32'h4000_0000);
    beat("bst_d1", 0, 0, 1, {32'h0, 32'h4000_0000});
    beat("bst_s2", 0, 0, 0, 64'h0);
    beat("bst_d2", 0, 1, 1, {32'h4000_0000, 32'h0}, 8'h0F);
    check_thr("bst_val", 0, 30'd16);
    idle("bst_i", 1);

    // two DWs in one beat, same channel: EN then DIS
    beat("ed3_h", 1, 0, 1, hdr(FT_WR64, 10'd2, 4'hF));
    beat("ed3_a", 0, 0, 1, {32'h0, reg_addr(3, 0)});
    expect_dw(3, 0, 32'h0);
    expect_dw(3, 1, 32'h0);
    beat("ed3_d", 0, 1, 1, 64'h0);
    idle("ed3_i", 1);

    // 5) negatives: wrong BAR, MRd, ch>=NUM_CH, off<0, first BE=0
    beat("nbar_h", 1, 0, 1, hdr(FT_WR32, 10'd1, 4'hF), 8'h00, 1'b0);
    beat("nbar_d", 0, 1, 1, {reg_addr(1, 0), 32'h0}, 8'h00, 1'b0);
    beat("mrd_h", 1, 0, 1, hdr(FT_RD32, 10'd1, 4'hF));
    beat("mrd_d", 0, 1, 1, {reg_addr(1, 0), 32'h0});
    beat("nch_h", 1, 0, 1, hdr(FT_WR32, 10'd1, 4'hF));
    beat("nch_d", 0, 1, 1, {reg_addr(4, 0), 32'h0});
    beat("neg_h", 1, 0, 1, hdr(FT_WR32, 10'd1, 4'hF));
    beat("neg_d", 0, 1, 1, {32'h0000_0014, 32'h0});
    beat("be0_h", 1, 0, 1, hdr(FT_WR32, 10'd1, 4'h0));
    beat("be0_d", 0, 1, 1, {reg_addr(1, 0), 32'h0});
    idle("neg_i", 1);

    // early eof: only the first of three DWs applies
    beat("eof_h", 1, 0, 1, hdr(FT_WR32, 10'd3, 4'hF));
    expect_dw(1, 1, 32'h0);
    beat("eof_d", 0, 1, 1, {reg_addr(1, 1), 32'h0});
    beat("eof_x", 0, 0, 1, {32'h0, 32'h0000_0080});
    idle("eof_i", 1);

    // sof mid-TLP aborts the old one and decodes the new header
    beat("ab_h0", 1, 0, 1, hdr(FT_WR32, 10'd4, 4'hF));
    expect_dw(2, 0, 32'h0);
    beat("ab_d0", 0, 0, 1, {reg_addr(2, 0), 32'h0});
    beat("ab_h1", 1, 0, 1, hdr(FT_WR32, 10'd1, 4'hF));
    expect_dw(0, 1, 32'h0);
    beat("ab_d1", 0, 1, 1, {reg_addr(0, 1), 32'h0});
    idle("ab_i", 1);

    // 6) reset mid-burst, then a fresh TLP decodes normally
    beat("rb_h", 1, 0, 1, hdr(FT_WR32, 10'd4, 4'hF));
    expect_dw(1, 0, 32'h0);
    beat("rb_d0", 0, 0, 1, {reg_addr(1, 0), 32'h0});
    do_reset("rb_rst");
    beat("rb_d1", 0, 0, 1, {32'h0, 32'h8000_0000});
    beat("rb_h2", 1, 0, 1, hdr(FT_WR32, 10'd1, 4'hF));
    expect_dw(1, 2, 32'h8000_0000);
    beat("rb_d2", 0, 1, 1, {reg_addr(1, 2), 32'h8000_0000});
    check_thr("rb_val", 1, 30'd32);
    idle("rb_i", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
